// File: rtl/branch_resolve_unit.sv
// EX-side branch resolution: mispredict flush FSM plus a 2-entry BTB update queue.
// Optional statistics counters are built when BRU_STATS_EN is defined.
module branch_resolve_unit #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    ex_valid,
  input  logic                    ex_is_branch,
  input  logic [PC_W-1:0]         ex_pc,
  input  logic                    ex_taken,
  input  logic [PC_W-1:0]         ex_target,
  input  logic                    ex_pred_hit,
  input  logic                    ex_pred_taken,
  input  logic [PC_W-1:0]         ex_pred_target,
  input  logic [1:0]              ex_pred_ctr,
  output logic                    flush,
  output logic [PC_W-1:0]         redirect_pc,
  output logic                    insert_nope,
  output logic                    btb_wr_valid,
  input  logic                    btb_wr_ready,
  output logic [IDX_W-1:0]        btb_wr_idx,
  output logic [PC_W-IDX_W-3:0]   btb_wr_tag,
  output logic [PC_W-1:0]         btb_wr_target,
  output logic [1:0]              btb_wr_ctr,
  output logic                    btb_wr_entry_valid,
  output logic [15:0]             stat_branches,
  output logic [15:0]             stat_mispred,
  output logic [15:0]             stat_drops
);

  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  tgt;
    logic [1:0]       ctr;
    logic             ev;
  } upd_t;

  state_t          state;
  logic            accept;
  logic            mispred;
  logic            upd_en;
  logic [PC_W-1:0] corr_pc;
  upd_t            upd;

  always_comb begin
    accept = ex_valid && !stall && (state == IDLE);
    if (ex_is_branch)
      mispred = (ex_pred_taken != ex_taken) ||
                (ex_taken && (ex_pred_target != ex_target));
    else
      mispred = ex_pred_taken;
    corr_pc = (ex_taken && ex_is_branch) ? ex_target
                                         : ex_pc + PC_W'(4);
  end

  always_comb begin
    upd_en  = 1'b0;
    upd.idx = ex_pc[IDX_W+1:2];
    upd.tag = ex_pc[PC_W-1:IDX_W+2];
    upd.tgt = ex_target;
    upd.ctr = 2'b00;
    upd.ev  = 1'b1;
    unique case (1'b1)
      ex_is_branch && ex_pred_hit: begin
        upd_en = 1'b1;
        if (ex_taken)
          upd.ctr = (ex_pred_ctr == 2'b11) ? 2'b11
                                           : ex_pred_ctr + 2'b01;
        else
          upd.ctr = (ex_pred_ctr == 2'b00) ? 2'b00
                                           : ex_pred_ctr - 2'b01;
      end
      ex_is_branch && !ex_pred_hit: begin
        upd_en  = ex_taken;
        upd.ctr = 2'b10;
      end
      !ex_is_branch && ex_pred_hit: begin
        upd_en = 1'b1;
        upd.ev = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      flush       <= 1'b0;
      redirect_pc <= '0;
      insert_nope <= 1'b0;
    end else if (!stall) begin
      unique case (state)
        IDLE: begin
          if (accept && mispred) begin
            state       <= FLUSH;
            flush       <= 1'b1;
            redirect_pc <= corr_pc;
            insert_nope <= 1'b1;
          end
        end
        FLUSH: begin
          state       <= DRAIN;
          flush       <= 1'b0;
          insert_nope <= 1'b1;
        end
        DRAIN: begin
          state       <= IDLE;
          insert_nope <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          flush       <= 1'b0;
          insert_nope <= 1'b0;
        end
      endcase
    end
  end

  // Two-slot ring: write slot is rd_ptr offset by the occupancy.
  upd_t       mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  logic       do_push;
  upd_t       head;

  always_comb begin
    btb_wr_valid = (count != 2'd0);
    pop          = btb_wr_valid && btb_wr_ready;
    push         = accept && upd_en;
    do_push      = push && ((count != 2'd2) || pop);
    wr_ptr       = rd_ptr ^ count[0];
    head         = btb_wr_valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push)
      mem[wr_ptr] <= upd;
  end

  assign btb_wr_idx         = head.idx;
  assign btb_wr_tag         = head.tag;
  assign btb_wr_target      = head.tgt;
  assign btb_wr_ctr         = head.ctr;
  assign btb_wr_entry_valid = head.ev;

`ifdef BRU_STATS_EN
  logic        drop;
  logic [15:0] n_br;
  logic [15:0] n_mp;
  logic [15:0] n_dr;

  assign drop = push && (count == 2'd2) && !pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      n_br <= '0;
      n_mp <= '0;
      n_dr <= '0;
    end else begin
      if (accept && ex_is_branch && (n_br != 16'hFFFF))
        n_br <= n_br + 16'd1;
      if (accept && mispred && (n_mp != 16'hFFFF))
        n_mp <= n_mp + 16'd1;
      if (drop && (n_dr != 16'hFFFF))
        n_dr <= n_dr + 16'd1;
    end
  end

  assign stat_branches = n_br;
  assign stat_mispred  = n_mp;
  assign stat_drops    = n_dr;
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
  assign stat_drops    = '0;
`endif

endmodule
